// File: rtl/core_pkg.sv
// core_pkg: shared ALU control codes, datapath widths and EX-stage register layout.
package core_pkg;
  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_ANDN = 3'b100,
    ALU_ORN  = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_con_t;
  typedef enum logic [1:0] {FWD_REG, FWD_MEM, FWD_WB} fwd_sel_t;
  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic               mem_read;
    logic               alu_src;
    alu_con_t           con;
    logic [RADDR_W-1:0] rd_addr;
    logic [RADDR_W-1:0] rs_addr;
    logic [RADDR_W-1:0] rt_addr;
    logic [XLEN-1:0]    rs_data;
    logic [XLEN-1:0]    rt_data;
    logic [XLEN-1:0]    imm;
  } ex_regs_t;
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: picks the freshest value of one source register from MEM, WB or the regfile copy.
module fwd_mux
  import core_pkg::*;
(
  input  logic [RADDR_W-1:0] addr,
  input  logic [XLEN-1:0]    reg_data,
  input  logic               mem_reg_write,
  input  logic [RADDR_W-1:0] mem_rd_addr,
  input  logic [XLEN-1:0]    mem_result,
  input  logic               wb_reg_write,
  input  logic [RADDR_W-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]    wb_result,
  output logic [XLEN-1:0]    data
);
  fwd_sel_t sel;
  always_comb begin
    sel  = (mem_reg_write && mem_rd_addr != '0 && mem_rd_addr == addr) ? FWD_MEM :
           (wb_reg_write && wb_rd_addr != '0 && wb_rd_addr == addr)    ? FWD_WB  : FWD_REG;
    data = sel == FWD_MEM ? mem_result : sel == FWD_WB ? wb_result : reg_data;
  end
endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX register with operand forwarding and load-use hazard detection.
module ex_operand_stage
  import core_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] id_rs_addr,
  input  logic [RADDR_W-1:0] id_rt_addr,
  input  logic [RADDR_W-1:0] id_rd_addr,
  input  logic [XLEN-1:0]    id_rs_data,
  input  logic [XLEN-1:0]    id_rt_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic               id_alu_src,
  input  logic               id_uses_rt,
  input  logic [2:0]         id_alu_con,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               mem_reg_write,
  input  logic [RADDR_W-1:0] mem_rd_addr,
  input  logic [XLEN-1:0]    mem_result,
  input  logic               wb_reg_write,
  input  logic [RADDR_W-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]    wb_result,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic [XLEN-1:0]    op1,
  output logic [XLEN-1:0]    op2,
  output logic [2:0]         con,
  output logic [XLEN-1:0]    store_data,
  output logic               ex_valid,
  output logic [RADDR_W-1:0] ex_rd_addr,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               hazard_o
);
  ex_regs_t ex_q, ex_d, cap, held;
  logic [XLEN-1:0] fwd_rs, fwd_rt;
  fwd_mux u_fwd_rs (
    .addr(ex_q.rs_addr), .reg_data(ex_q.rs_data),
    .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
    .data(fwd_rs)
  );
  fwd_mux u_fwd_rt (
    .addr(ex_q.rt_addr), .reg_data(ex_q.rt_data),
    .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
    .data(fwd_rt)
  );
  assign hazard_o = ex_q.valid && ex_q.mem_read && ex_q.rd_addr != '0 && id_valid &&
                    (ex_q.rd_addr == id_rs_addr || (id_uses_rt && ex_q.rd_addr == id_rt_addr));
  always_comb begin
    cap           = '0;
    cap.valid     = id_valid;
    cap.reg_write = id_reg_write && id_valid;
    cap.mem_read  = id_mem_read && id_valid;
    cap.alu_src   = id_alu_src;
    cap.con       = alu_con_t'(id_alu_con);
    cap.rd_addr   = id_rd_addr;
    cap.rs_addr   = id_rs_addr;
    cap.rt_addr   = id_rt_addr;
    cap.rs_data   = id_rs_data;
    cap.rt_data   = id_rt_data;
    cap.imm       = id_imm;
    // A frozen EX keeps absorbing forwarded operands so a retiring producer is not lost.
    held          = ex_q;
    held.rs_data  = fwd_rs;
    held.rt_data  = fwd_rt;
    ex_d          = flush_i ? '0 : stall_i ? held : hazard_o ? '0 : cap;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) ex_q <= '0;
    else ex_q <= ex_d;
  end
  assign op1          = fwd_rs;
  assign op2          = ex_q.alu_src ? ex_q.imm : fwd_rt;
  assign store_data   = fwd_rt;
  assign con          = ex_q.con;
  assign ex_valid     = ex_q.valid;
  assign ex_rd_addr   = ex_q.rd_addr;
  assign ex_reg_write = ex_q.reg_write && ex_q.valid;
  assign ex_mem_read  = ex_q.mem_read && ex_q.valid;
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed scenarios plus randomized cycles checked against a behavioural EX model.
module tb_ex_operand_stage;
  import core_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, id_valid, id_alu_src, id_uses_rt, id_reg_write, id_mem_read;
  logic [4:0] id_rs_addr, id_rt_addr, id_rd_addr, mem_rd_addr, wb_rd_addr, ex_rd_addr;
  logic [31:0] id_rs_data, id_rt_data, id_imm, mem_result, wb_result;
  logic [2:0] id_alu_con, con;
  logic mem_reg_write, wb_reg_write, stall_i, flush_i;
  logic [31:0] op1, op2, store_data;
  logic ex_valid, ex_reg_write, ex_mem_read, hazard_o;
  int n_cmp = 0, n_bad = 0;

  ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rd_addr(id_rd_addr), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_uses_rt(id_uses_rt), .id_alu_con(id_alu_con),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .mem_reg_write(mem_reg_write),
    .mem_rd_addr(mem_rd_addr), .mem_result(mem_result), .wb_reg_write(wb_reg_write),
    .wb_rd_addr(wb_rd_addr), .wb_result(wb_result), .stall_i(stall_i), .flush_i(flush_i),
    .op1(op1), .op2(op2), .con(con), .store_data(store_data), .ex_valid(ex_valid),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .hazard_o(hazard_o)
  );

  // Reference model: the instruction currently sitting in EX, as the spec describes it.
  typedef struct {
    bit v, rw, mr, src;
    logic [2:0] con;
    logic [4:0] rd, rs, rt;
    logic [31:0] rsd, rtd, imm;
  } ex_t;
  ex_t m;

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] r);
    if (mem_reg_write && mem_rd_addr != 0 && mem_rd_addr == a) return mem_result;
    if (wb_reg_write && wb_rd_addr != 0 && wb_rd_addr == a) return wb_result;
    return r;
  endfunction

  function automatic bit load_use();
    return m.v && m.mr && m.rd != 0 && id_valid &&
           (m.rd == id_rs_addr || (id_uses_rt && m.rd == id_rt_addr));
  endfunction

  task automatic tick();
    ex_t nx;
    nx = m;
    if (!rst_n || flush_i || (!stall_i && load_use())) nx = '{default: 0};
    else if (stall_i) begin
      nx.rsd = fwd(m.rs, m.rsd);
      nx.rtd = fwd(m.rt, m.rtd);
    end else begin
      nx.v = id_valid; nx.rw = id_valid && id_reg_write; nx.mr = id_valid && id_mem_read;
      nx.src = id_alu_src; nx.con = id_alu_con; nx.rd = id_rd_addr; nx.rs = id_rs_addr;
      nx.rt = id_rt_addr; nx.rsd = id_rs_data; nx.rtd = id_rt_data; nx.imm = id_imm;
    end
    @(posedge clk);
    m = nx;
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0; id_rs_data = 0; id_rt_data = 0;
    id_imm = 0; id_alu_src = 0; id_uses_rt = 0; id_alu_con = 0; id_reg_write = 0; id_mem_read = 0;
    mem_reg_write = 0; mem_rd_addr = 0; mem_result = 0; wb_reg_write = 0; wb_rd_addr = 0;
    wb_result = 0; stall_i = 0; flush_i = 0;
  endtask

  task automatic issue(input logic [4:0] rs, rt, rd, input logic [31:0] rsd, rtd, imm,
                       input logic src, ut, input logic [2:0] c, input logic rw, mr);
    id_valid = 1; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd; id_rs_data = rsd;
    id_rt_data = rtd; id_imm = imm; id_alu_src = src; id_uses_rt = ut; id_alu_con = c;
    id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    issue(5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'h33, 1'b1, 1'b1, 3'b010, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp += 4;
      if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", ex_valid); end
      if (op1 !== 32'h0 || op2 !== 32'h0 || store_data !== 32'h0) begin
        n_bad++; $display("FAIL reset_ops got %h/%h/%h exp 0", op1, op2, store_data);
      end
      if (con !== 3'b000) begin n_bad++; $display("FAIL reset_con got %b exp 000", con); end
      if (hazard_o !== 1'b0) begin n_bad++; $display("FAIL reset_hazard got %b exp 0", hazard_o); end
    end
    rst_n = 1;
    idle();
    tick();
    n_cmp += 3;
    if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_valid got %b exp 0", ex_valid); end
    if (op1 !== 32'h0 || op2 !== 32'h0) begin n_bad++; $display("FAIL post_reset_ops got %h/%h exp 0", op1, op2); end
    if (hazard_o !== 1'b0) begin n_bad++; $display("FAIL post_reset_hazard got %b exp 0", hazard_o); end
  endtask

  task automatic test_mem_forward();
    idle();
    issue(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, ALU_ADD, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if ({op1, op2, con} !== {32'd5, 32'd7, 3'b010}) begin
      n_bad++; $display("FAIL add_ops got %h %h %b exp 5 7 010", op1, op2, con);
    end
    issue(5'd3, 5'd1, 5'd4, 32'd0, 32'd5, 32'd0, 1'b0, 1'b1, ALU_SUB, 1'b1, 1'b0);
    tick();
    mem_reg_write = 1; mem_rd_addr = 5'd3; mem_result = 32'd12;
    #1;
    n_cmp += 3;
    if (op1 !== 32'd12) begin n_bad++; $display("FAIL sub_mem_fwd_op1 got %h exp c", op1); end
    if (op2 !== 32'd5) begin n_bad++; $display("FAIL sub_op2 got %h exp 5", op2); end
    if (con !== 3'b110) begin n_bad++; $display("FAIL sub_con got %b exp 110", con); end
  endtask

  task automatic test_priority();
    idle();
    issue(5'd3, 5'd0, 5'd6, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0, ALU_OR, 1'b1, 1'b0);
    tick();
    mem_reg_write = 1; mem_rd_addr = 5'd3; mem_result = 32'hAA;
    wb_reg_write = 1; wb_rd_addr = 5'd3; wb_result = 32'hBB;
    #1;
    n_cmp++;
    if (op1 !== 32'hAA) begin n_bad++; $display("FAIL mem_beats_wb got %h exp aa", op1); end
    mem_reg_write = 0;
    #1;
    n_cmp++;
    if (op1 !== 32'hBB) begin n_bad++; $display("FAIL wb_forward got %h exp bb", op1); end
    issue(5'd0, 5'd0, 5'd6, 32'h55, 32'h66, 32'h0, 1'b0, 1'b1, ALU_OR, 1'b1, 1'b0);
    mem_reg_write = 0; wb_reg_write = 0;
    tick();
    mem_reg_write = 1; mem_rd_addr = 5'd0; mem_result = 32'hAA;
    wb_reg_write = 1; wb_rd_addr = 5'd0; wb_result = 32'hBB;
    #1;
    n_cmp++;
    if (op1 !== 32'h55 || store_data !== 32'h66) begin
      n_bad++; $display("FAIL r0_no_forward got %h/%h exp 55/66", op1, store_data);
    end
  endtask

  task automatic test_load_use();
    idle();
    issue(5'd1, 5'd0, 5'd5, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0, ALU_ADD, 1'b1, 1'b1);
    tick();
    issue(5'd5, 5'd2, 5'd7, 32'h0, 32'h9, 32'h0, 1'b0, 1'b1, ALU_ADD, 1'b1, 1'b0);
    #1;
    n_cmp++;
    if (hazard_o !== 1'b1) begin n_bad++; $display("FAIL load_use_hazard got %b exp 1", hazard_o); end
    tick();
    mem_reg_write = 1; mem_rd_addr = 5'd5; mem_result = 32'h100;
    #1;
    n_cmp += 2;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
      n_bad++; $display("FAIL load_use_bubble got %b%b exp 00", ex_valid, ex_reg_write);
    end
    if (hazard_o !== 1'b0) begin n_bad++; $display("FAIL hazard_one_cycle got %b exp 0", hazard_o); end
    tick();
    mem_reg_write = 0;
    wb_reg_write = 1; wb_rd_addr = 5'd5; wb_result = 32'hCAFE;
    #1;
    n_cmp++;
    if (op1 !== 32'hCAFE || ex_valid !== 1'b1) begin
      n_bad++; $display("FAIL load_use_wb_fwd got %h/%b exp cafe/1", op1, ex_valid);
    end
  endtask

  task automatic test_stall();
    idle();
    issue(5'd6, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, ALU_ADD, 1'b1, 1'b0);
    wb_reg_write = 1; wb_rd_addr = 5'd6; wb_result = 32'h1234;
    tick();
    n_cmp++;
    if (op1 !== 32'h1234) begin n_bad++; $display("FAIL stall_pre_op1 got %h exp 1234", op1); end
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      wb_reg_write = 0;
      issue(5'd2, 5'd3, 5'd4, 32'hDEAD, 32'hBEEF, 32'h0, 1'b0, 1'b1, ALU_OR, 1'b1, 1'b0);
      #1;
      n_cmp++;
      if (op1 !== 32'h1234) begin n_bad++; $display("FAIL stall_hold_op1 got %h exp 1234", op1); end
    end
    stall_i = 0;
    #1;
    n_cmp++;
    if (ex_rd_addr !== 5'd9 || op1 !== 32'h1234) begin
      n_bad++; $display("FAIL stall_release got rd=%0d op1=%h exp rd=9 op1=1234", ex_rd_addr, op1);
    end
  endtask

  task automatic test_flush();
    idle();
    issue(5'd1, 5'd2, 5'd8, 32'h7, 32'h8, 32'h0, 1'b0, 1'b1, ALU_AND, 1'b1, 1'b1);
    tick();
    flush_i = 1; stall_i = 1;
    tick();
    flush_i = 0; stall_i = 0;
    #1;
    n_cmp += 2;
    if ({ex_valid, ex_reg_write, ex_mem_read} !== 3'b000) begin
      n_bad++; $display("FAIL flush_bubble_ctl got %b exp 000", {ex_valid, ex_reg_write, ex_mem_read});
    end
    if (op1 !== 32'h0 || ex_rd_addr !== 5'd0) begin
      n_bad++; $display("FAIL flush_bubble_data got %h/%0d exp 0/0", op1, ex_rd_addr);
    end
    issue(5'd0, 5'd7, 5'd2, 32'h0, 32'h11, 32'hFFFFFFFC, 1'b1, 1'b0, ALU_ADD, 1'b1, 1'b0);
    wb_reg_write = 1; wb_rd_addr = 5'd7; wb_result = 32'h77;
    tick();
    n_cmp += 2;
    if (op2 !== 32'hFFFFFFFC) begin n_bad++; $display("FAIL imm_op2 got %h exp fffffffc", op2); end
    if (store_data !== 32'h77) begin n_bad++; $display("FAIL store_data_fwd got %h exp 77", store_data); end
  endtask

  task automatic test_random();
    logic [31:0] e_rt;
    for (int i = 0; i < 400; i++) begin
      issue(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 3'($urandom),
            1'($urandom), 1'($urandom_range(0, 2) == 0));
      id_valid = ($urandom_range(0, 4) != 0);
      mem_reg_write = 1'($urandom); mem_rd_addr = 5'($urandom_range(0, 3)); mem_result = $urandom;
      wb_reg_write = 1'($urandom); wb_rd_addr = 5'($urandom_range(0, 3)); wb_result = $urandom;
      stall_i = ($urandom_range(0, 7) == 0);
      flush_i = ($urandom_range(0, 15) == 0);
      #1;
      e_rt = fwd(m.rt, m.rtd);
      n_cmp += 4;
      if (op1 !== fwd(m.rs, m.rsd)) begin n_bad++; $display("FAIL rand_op1 cyc %0d got %h exp %h", i, op1, fwd(m.rs, m.rsd)); end
      if (op2 !== (m.src ? m.imm : e_rt)) begin n_bad++; $display("FAIL rand_op2 cyc %0d got %h exp %h", i, op2, m.src ? m.imm : e_rt); end
      if (store_data !== e_rt) begin n_bad++; $display("FAIL rand_store cyc %0d got %h exp %h", i, store_data, e_rt); end
      if ({ex_valid, ex_reg_write, ex_mem_read, ex_rd_addr, con, hazard_o} !==
          {m.v, m.v && m.rw, m.v && m.mr, m.rd, m.con, load_use()}) begin
        n_bad++;
        $display("FAIL rand_ctrl cyc %0d got %b exp %b", i,
                 {ex_valid, ex_reg_write, ex_mem_read, ex_rd_addr, con, hazard_o},
                 {m.v, m.v && m.rw, m.v && m.mr, m.rd, m.con, load_use()});
      end
      tick();
    end
  endtask

  initial begin
    m = '{default: 0};
    test_reset();
    test_mem_forward();
    test_priority();
    test_load_use();
    test_stall();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
